line_pingpong: RTL and testbench
================================

LINE_PINGPONG -- requirements
Module: line_pingpong

Interface
- REQ-001: Parameter AW, default 9: address width; each bank holds 2**AW entries.
- REQ-002: Parameter DW, default 8: pixel width.
- REQ-003: Parameter TRANSP, default 0: DW-bit transparent/cleared pixel value.
- REQ-004: Parameter PRIO, default 0: 0 = last opaque write wins; 1 = first opaque write wins.
- REQ-005: Parameter CLR, default 1: 1 = read-and-clear; 0 = read leaves the entry intact.
- REQ-006: CLK, input, 1 bit: single clock; all state changes on the rising edge.
- REQ-007: RESET, input, 1 bit: synchronous, active-high reset.
- REQ-008: SWAP, input, 1 bit: one-cycle pulse that exchanges the write and read banks.
- REQ-009: WR_EN, input, 1 bit: pixel write request.
- REQ-010: WR_AD, input, AW bits: pixel write address.
- REQ-011: WR_DI, input, DW bits: pixel write data.
- REQ-012: RD_EN, input, 1 bit: scan read request.
- REQ-013: RD_AD, input, AW bits: scan read address.
- REQ-014: RD_DO, output, DW bits: registered scan read data.
- REQ-015: BANK, output, 1 bit: current write bank; the read bank is ~BANK.
- REQ-016: BUSY, output, 1 bit: post-reset clear sweep in progress.

Function
- REQ-017: Storage SHALL be two banks of 2**AW x DW; RD_AD and WR_AD each address only their own bank.
- REQ-018: BANK SHALL toggle on the edge where SWAP=1 and BUSY=0; SWAP during BUSY SHALL be ignored.
- REQ-019: A write SHALL pass through a 2-stage pipeline.
  - S1: captures address, data and BANK at issue, and reads the stored pixel.
  - S2: commits the write on the following edge.
- REQ-020: A write SHALL commit to the bank captured at issue, even if SWAP occurs while it is in flight.
- REQ-021: A write with WR_DI==TRANSP SHALL never modify memory.
- REQ-022: With PRIO=0, S2 SHALL commit every opaque write.
- REQ-023: With PRIO=1, S2 SHALL commit only if the S1-read pixel equals TRANSP.
- REQ-024: When S2 commits to the same bank and address that S1 is reading, S1 SHALL use S2's data in place of the memory value (forwarding). Back-to-back writes SHALL therefore behave as if strictly sequential.
- REQ-025: Writes SHALL be accepted every cycle, with no stall and no backpressure.
- REQ-026: RD_EN=1 at edge n SHALL present the read-bank entry on RD_DO after edge n; RD_DO SHALL hold its value when RD_EN=0.
- REQ-027: With CLR=1, a read SHALL write TRANSP to the same entry on the same edge, read-before-write; RD_DO returns the old value.
- REQ-028: If an S2 commit and a read-clear target the same bank and address on the same edge, the S2 commit SHALL win and the clear SHALL be dropped.
- REQ-029: Reading an address that S2 is committing on the same edge SHALL return the pre-commit value.
- REQ-030: While BUSY=1, WR_EN and RD_EN SHALL be ignored.

Reset
- REQ-031: RESET SHALL set BANK=0, RD_DO=TRANSP, clear both pipeline valid flags (in-flight writes discarded), set BUSY=1 and set the sweep counter to 0.
- REQ-032: During the sweep, each cycle SHALL write TRANSP to counter address in both banks, then increment the counter.
- REQ-033: BUSY SHALL fall on the edge after address 2**AW-1 is written, i.e. BUSY is high for exactly 2**AW cycles after RESET deasserts.
- REQ-034: RESET asserted mid-sweep SHALL restart the sweep from address 0.

Verification (AW=4, DW=8, TRANSP=0)
- REQ-035: Reset then idle -> BUSY high for exactly 16 cycles; afterwards every read returns 0x00 in both banks.
- REQ-036: PRIO=0: writes 0x11 then 0x22 to addr 5 on consecutive cycles; SWAP; read addr 5 -> RD_DO=0x22 one cycle later; re-read -> 0x00 (CLR=1).
- REQ-037: PRIO=1: same stimulus as REQ-036 -> RD_DO=0x11. Additionally, write 0x00 then 0x33 to addr 6 -> RD_DO=0x33.
- REQ-038: Write 0x44 to addr 3 with SWAP on the same edge as S1 -> 0x44 lands in the old write bank; it is readable immediately after the swap and absent after a second SWAP.
- REQ-039: CLR=0: read addr 7 holding 0x55 twice -> both reads return 0x55.
- REQ-040: RESET for one cycle while S1 and S2 hold valid writes to addr 9 -> addr 9 reads 0x00 after the sweep, and BANK=0.

Source files
------------

// File: rtl/line_pingpong_if.sv
// rtl/line_pingpong_if.sv - pixel write / scan read / bank control bundle for line_pingpong
interface line_pingpong_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          swap;
    logic          wr_en;
    logic [AW-1:0] wr_ad;
    logic [DW-1:0] wr_di;
    logic          rd_en;
    logic [AW-1:0] rd_ad;
    logic [DW-1:0] rd_do;
    logic          bank;
    logic          busy;

    modport master (
        output swap, wr_en, wr_ad, wr_di, rd_en, rd_ad,
        input  rd_do, bank, busy
    );

    modport slave (
        input  swap, wr_en, wr_ad, wr_di, rd_en, rd_ad,
        output rd_do, bank, busy
    );
endinterface

// File: rtl/line_pingpong.sv
// rtl/line_pingpong.sv - ping-pong line buffer with pipelined priority pixel writes and read-and-clear scan
module line_pingpong #(
    parameter int            AW     = 9,
    parameter int            DW     = 8,
    parameter logic [DW-1:0] TRANSP = '0,
    parameter int            PRIO   = 0,
    parameter int            CLR    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    line_pingpong_if.slave    bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {ST_SWEEP, ST_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_busy;
    logic [AW-1:0] r_cnt;
    logic          w_sweep_last;

    logic [DW-1:0] r_mem [0:1][0:DEPTH-1];

    logic          r_bank;
    logic [DW-1:0] r_rd_do;

    logic          r_s1_valid;
    logic          r_s1_bank;
    logic [AW-1:0] r_s1_ad;
    logic [DW-1:0] r_s1_di;
    logic [DW-1:0] r_s1_px;

    logic          w_wr_req;
    logic          w_rd_req;
    logic          w_swap;
    logic          w_rd_bank;
    logic          w_s2_commit;
    logic          w_fwd;
    logic [DW-1:0] w_s1_px;
    logic          w_clr;

    // Clear sweep FSM: runs after every reset, then stays in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_SWEEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_SWEEP;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_SWEEP);
    end

    assign w_sweep_last = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_wr_req  = bus.wr_en & ~w_busy;
    assign w_rd_req  = bus.rd_en & ~w_busy;
    assign w_swap    = bus.swap  & ~w_busy;
    assign w_rd_bank = ~r_bank;

    // S2 decision is taken from the S1 registers; the stored pixel was sampled at issue.
    assign w_s2_commit = r_s1_valid && (r_s1_di != TRANSP) &&
                         ((PRIO == 0) || (r_s1_px == TRANSP));

    assign w_fwd   = w_s2_commit && (r_s1_bank == r_bank) && (r_s1_ad == bus.wr_ad);
    assign w_s1_px = w_fwd ? r_s1_di : r_mem[r_bank][bus.wr_ad];

    // A commit landing on the entry being scanned out beats that entry's clear.
    assign w_clr = (CLR != 0) && w_rd_req &&
                   !(w_s2_commit && (r_s1_bank == w_rd_bank) && (r_s1_ad == bus.rd_ad));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_wr_req;
            if (w_wr_req) begin
                r_s1_bank <= r_bank;
                r_s1_ad   <= bus.wr_ad;
                r_s1_di   <= bus.wr_di;
                r_s1_px   <= w_s1_px;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_busy) begin
                r_mem[0][r_cnt] <= TRANSP;
                r_mem[1][r_cnt] <= TRANSP;
            end else begin
                if (w_clr) begin
                    r_mem[w_rd_bank][bus.rd_ad] <= TRANSP;
                end
                if (w_s2_commit) begin
                    r_mem[r_s1_bank][r_s1_ad] <= r_s1_di;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank  <= 1'b0;
            r_rd_do <= TRANSP;
        end else begin
            if (w_swap) begin
                r_bank <= ~r_bank;
            end
            if (w_rd_req) begin
                r_rd_do <= r_mem[w_rd_bank][bus.rd_ad];
            end
        end
    end

    assign bus.rd_do = r_rd_do;
    assign bus.bank  = r_bank;
    assign bus.busy  = w_busy;
endmodule

// File: tb/tb_line_pingpong.sv
// tb/tb_line_pingpong.sv - three-configuration bench for line_pingpong against a sequential reference model
module tb_line_pingpong;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          swap = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_ad = '0;
    logic [DW-1:0] wr_di = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_ad = '0;

    logic [DW-1:0] d_rd   [3];
    logic          d_bank [3];
    logic          d_busy [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    // cfg 0: PRIO=0 CLR=1, cfg 1: PRIO=1 CLR=1, cfg 2: PRIO=0 CLR=0
    for (genvar g = 0; g < 3; g++) begin : g_dut
        line_pingpong_if #(.AW(AW), .DW(DW)) u_if ();
        assign u_if.swap  = swap;
        assign u_if.wr_en = wr_en;
        assign u_if.wr_ad = wr_ad;
        assign u_if.wr_di = wr_di;
        assign u_if.rd_en = rd_en;
        assign u_if.rd_ad = rd_ad;
        line_pingpong #(
            .AW(AW), .DW(DW), .TRANSP(8'h00),
            .PRIO((g == 1) ? 1 : 0), .CLR((g == 2) ? 0 : 1)
        ) dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (u_if.slave)
        );
        assign d_rd[g]   = u_if.rd_do;
        assign d_bank[g] = u_if.bank;
        assign d_busy[g] = u_if.busy;
    end

    // Reference model: each edge is an ordered list of events on plain arrays.
    int            prio_c [3] = '{0, 1, 0};
    int            clr_c  [3] = '{1, 1, 0};
    logic [DW-1:0] mem    [3][2][16];
    logic          m_bank [3];
    logic          m_busy [3];
    logic [DW-1:0] m_rd   [3];
    int            m_cnt  [3];
    logic          p_v    [3];
    logic          p_b    [3];
    logic [AW-1:0] p_ad   [3];
    logic [DW-1:0] p_di   [3];

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            logic rb;
            logic commit;
            if (rst) begin
                m_bank[c] = 1'b0;
                m_rd[c]   = 8'h00;
                m_busy[c] = 1'b1;
                m_cnt[c]  = 0;
                p_v[c]    = 1'b0;
            end else if (m_busy[c]) begin
                mem[c][0][m_cnt[c]] = 8'h00;
                mem[c][1][m_cnt[c]] = 8'h00;
                m_cnt[c]++;
                if (m_cnt[c] == 16) m_busy[c] = 1'b0;
            end else begin
                rb = !m_bank[c];
                commit = p_v[c] && (p_di[c] != 8'h00) &&
                         (prio_c[c] == 0 || mem[c][p_b[c]][p_ad[c]] == 8'h00);
                if (rd_en) begin
                    m_rd[c] = mem[c][rb][rd_ad];
                    if (clr_c[c] != 0 && !(commit && p_b[c] == rb && p_ad[c] == rd_ad))
                        mem[c][rb][rd_ad] = 8'h00;
                end
                if (commit) mem[c][p_b[c]][p_ad[c]] = p_di[c];
                p_v[c]  = wr_en;
                p_b[c]  = m_bank[c];
                p_ad[c] = wr_ad;
                p_di[c] = wr_di;
                if (swap) m_bank[c] = !m_bank[c];
            end
        end
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("cyc_rd_do[%0d] t=%0t", c, $time), d_rd[c], m_rd[c]);
                check($sformatf("cyc_bank[%0d] t=%0t", c, $time), {7'd0, d_bank[c]}, {7'd0, m_bank[c]});
                check($sformatf("cyc_busy[%0d] t=%0t", c, $time), {7'd0, d_busy[c]}, {7'd0, m_busy[c]});
            end
        end
    end

    task automatic lit3(input string nm, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                        input logic [DW-1:0] e2);
        check({nm, "_dut0"}, d_rd[0], e0);
        check({nm, "_dut1"}, d_rd[1], e1);
        check({nm, "_dut2"}, d_rd[2], e2);
        check({nm, "_mdl1"}, m_rd[1], e1);
        check({nm, "_mdl2"}, m_rd[2], e2);
    endtask

    task automatic tick(input logic s, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        swap = s; wr_en = we; wr_ad = wa; wr_di = wd; rd_en = re; rd_ad = ra;
        @(negedge clk);
    endtask

    task automatic idle();                                        tick(0, 0, 0, 0, 0, 0); endtask
    task automatic rd(input logic [AW-1:0] a);                    tick(0, 0, 0, 0, 1, a); endtask
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d); tick(0, 1, a, d, 0, 0); endtask
    task automatic sw();                                          tick(1, 0, 0, 0, 0, 0); endtask

    // Requests issued while busy must be ignored.
    task automatic count_busy(input string nm);
        int n = 0;
        while (d_busy[0] === 1'b1 && n < 40) begin
            n++;
            if (n == 1) tick(0, 1, 4'd2, 8'h77, 1, 4'd2);
            else        idle();
        end
        check(nm, 8'(n), 8'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        check("reset_rd_do", d_rd[0], 8'h00);
        check("reset_bank", {7'd0, d_bank[0]}, 8'h00);
        count_busy("busy_len_first");

        for (int a = 0; a < 16; a++) rd(4'(a));
        sw();
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            if (a == 2) lit3("busy_write_ignored", 8'h00, 8'h00, 8'h00);
        end
        check("bank_after_swap", {7'd0, d_bank[0]}, 8'h01);

        wr(4'd5, 8'h11); wr(4'd5, 8'h22); idle(); sw();
        rd(4'd5); lit3("prio_first_read", 8'h22, 8'h11, 8'h22);
        rd(4'd5); lit3("prio_reread", 8'h00, 8'h00, 8'h22);

        wr(4'd6, 8'h00); wr(4'd6, 8'h33); idle(); sw();
        rd(4'd6); lit3("transp_write", 8'h33, 8'h33, 8'h33);

        tick(1, 1, 4'd3, 8'h44, 0, 0); idle();
        rd(4'd3); lit3("swap_in_flight", 8'h44, 8'h44, 8'h44);
        sw();
        rd(4'd3); lit3("swap_back", 8'h00, 8'h00, 8'h00);

        tick(1, 1, 4'd4, 8'h66, 0, 0);
        rd(4'd4); lit3("rd_vs_commit_pre", 8'h00, 8'h00, 8'h00);
        rd(4'd4); lit3("commit_beats_clear", 8'h66, 8'h66, 8'h66);
        rd(4'd4); lit3("clear_after", 8'h00, 8'h00, 8'h66);

        wr(4'd7, 8'h55); idle(); sw();
        rd(4'd7); lit3("clr0_first", 8'h55, 8'h55, 8'h55);
        rd(4'd7); lit3("clr0_second", 8'h00, 8'h00, 8'h55);

        wr(4'd9, 8'h99); wr(4'd9, 8'h9A);
        rst = 1'b1; idle(); rst = 1'b0;
        check("reset2_bank", {7'd0, d_bank[2]}, 8'h00);
        lit3("reset2_rd_do", 8'h00, 8'h00, 8'h00);
        repeat (5) idle();
        rst = 1'b1; idle(); rst = 1'b0;
        count_busy("busy_len_restart");
        rd(4'd9); lit3("inflight_dropped_b1", 8'h00, 8'h00, 8'h00);
        sw();
        rd(4'd9); lit3("inflight_dropped_b0", 8'h00, 8'h00, 8'h00);
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
